feedback_packet_rx: RTL and testbench

- Upstream stage of the Q-table update block.
- Accepts byte-serial feedback/control packets from the radio/memory interface and assembles the 16-bit fields: source ID, cluster ID, energy left, Q-value and packet type.
- Presents the assembled fields to the Q-table updater with a one-cycle enable pulse, then holds them until the updater signals done.
- Also filters self-originated frames, recovers from stalled frames, and counts errors.

---
 rtl/feedback_packet_rx_if.sv | 32 +++
 rtl/feedback_packet_rx.sv | 155 +++++++++++++++
 tb/tb_feedback_packet_rx.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feedback_packet_rx_if.sv
// Byte stream and Q-table updater bundle for feedback_packet_rx.
// The slave modport is the receiver side; master is whoever drives the bytes and done.
`timescale 1ns/1ps
interface feedback_packet_rx_if #(
  parameter int unsigned ERR_W = 8
);
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             upd_done;
  logic             en;
  logic [15:0]      fSourceID;
  logic [15:0]      fClusterID;
  logic [15:0]      fEnergyLeft;
  logic [15:0]      fQValue;
  logic [2:0]       packetType;
  logic             busy;
  logic [ERR_W-1:0] err_count;
  logic [ERR_W-1:0] drop_count;

  modport master (
    output rx_data, rx_valid, upd_done,
    input  rx_ready, en, fSourceID, fClusterID, fEnergyLeft, fQValue,
           packetType, busy, err_count, drop_count
  );

  modport slave (
    input  rx_data, rx_valid, upd_done,
    output rx_ready, en, fSourceID, fClusterID, fEnergyLeft, fQValue,
           packetType, busy, err_count, drop_count
  );
endinterface

// File: rtl/feedback_packet_rx.sv
// Byte-serial feedback packet receiver feeding the Q-table updater.
// Define FEEDBACK_CSUM_EN to require a trailing XOR checksum byte on every frame.
`timescale 1ns/1ps
module feedback_packet_rx #(
  parameter logic [15:0] NODE_ID     = 16'h0001,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned ERR_W       = 8
) (
  input logic                 clock,
  input logic                 rst,
  feedback_packet_rx_if.slave rx
);
  localparam int unsigned   TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_HDR,
    S_BODY,
`ifdef FEEDBACK_CSUM_EN
    S_CSUM,
`endif
    S_CHK,
    S_ISSUE,
    S_WAIT
  } state_t;

  state_t           state;
  logic [2:0]       idx;
  logic [TW-1:0]    tcnt;
  logic [3:0][15:0] shWord;   // 0 source, 1 cluster, 2 energy, 3 Q-value
  logic [2:0]       shType;
  logic [ERR_W-1:0] errCnt;
  logic [ERR_W-1:0] dropCnt;
`ifdef FEEDBACK_CSUM_EN
  logic [7:0]       csumAcc;
`endif
  logic             accept;
  logic             hdrOk;

  assign accept        = rx.rx_valid && rx.rx_ready;
  assign hdrOk         = (rx.rx_data[2:0] >= 3'd1) && (rx.rx_data[2:0] <= 3'd4);
  assign rx.err_count  = errCnt;
  assign rx.drop_count = dropCnt;

  always_ff @(posedge clock) begin
    if (rst) begin
      state          <= S_HDR;
      idx            <= '0;
      tcnt           <= '0;
      shWord         <= '0;
      shType         <= '0;
      errCnt         <= '0;
      dropCnt        <= '0;
      rx.rx_ready    <= 1'b1;
      rx.en          <= 1'b0;
      rx.busy        <= 1'b0;
      rx.fSourceID   <= '0;
      rx.fClusterID  <= '0;
      rx.fEnergyLeft <= '0;
      rx.fQValue     <= '0;
      rx.packetType  <= '0;
`ifdef FEEDBACK_CSUM_EN
      csumAcc        <= '0;
`endif
    end else begin
      rx.en <= 1'b0;
      case (state)
        S_HDR: begin
          tcnt <= '0;
          if (accept && hdrOk) begin
            shType  <= rx.rx_data[2:0];
            idx     <= '0;
            rx.busy <= 1'b1;
            state   <= S_BODY;
`ifdef FEEDBACK_CSUM_EN
            csumAcc <= rx.rx_data;
`endif
          end
        end
        S_BODY: begin
          if (accept) begin
            tcnt                <= '0;
            shWord[idx[2:1]]    <= {shWord[idx[2:1]][7:0], rx.rx_data};
            idx                 <= idx + 3'd1;
`ifdef FEEDBACK_CSUM_EN
            csumAcc             <= csumAcc ^ rx.rx_data;
            if (idx == 3'd7) state <= S_CSUM;
`else
            if (idx == 3'd7) begin
              state       <= S_CHK;
              rx.rx_ready <= 1'b0;
            end
`endif
          end else if (tcnt == T_LAST) begin
            state   <= S_HDR;
            rx.busy <= 1'b0;
            if (errCnt != '1) errCnt <= errCnt + 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
`ifdef FEEDBACK_CSUM_EN
        S_CSUM: begin
          if (accept) begin
            tcnt <= '0;
            if (rx.rx_data == csumAcc) begin
              state       <= S_CHK;
              rx.rx_ready <= 1'b0;
            end else begin
              state   <= S_HDR;
              rx.busy <= 1'b0;
              if (errCnt != '1) errCnt <= errCnt + 1'b1;
            end
          end else if (tcnt == T_LAST) begin
            state   <= S_HDR;
            rx.busy <= 1'b0;
            if (errCnt != '1) errCnt <= errCnt + 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
`endif
        S_CHK: begin
          if (shWord[0] == NODE_ID) begin
            if (dropCnt != '1) dropCnt <= dropCnt + 1'b1;
            state       <= S_HDR;
            rx.rx_ready <= 1'b1;
            rx.busy     <= 1'b0;
          end else begin
            rx.fSourceID   <= shWord[0];
            rx.fClusterID  <= shWord[1];
            rx.fEnergyLeft <= shWord[2];
            rx.fQValue     <= shWord[3];
            rx.packetType  <= shType;
            rx.en          <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (rx.upd_done) begin
            state       <= S_HDR;
            rx.rx_ready <= 1'b1;
            rx.busy     <= 1'b0;
          end
        end
        default: begin
          state       <= S_HDR;
          rx.rx_ready <= 1'b1;
          rx.busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_feedback_packet_rx.sv
// Scoreboard bench for feedback_packet_rx: expected packets are queued as frames are sent
// and checked against each en pulse by a monitor on the falling edge.
`timescale 1ns/1ps
module tb_feedback_packet_rx;
  localparam int unsigned EW = 8;
  localparam int unsigned RZ = 69 + 2 * EW;

  typedef struct {
    logic [15:0] src;
    logic [15:0] clu;
    logic [15:0] eng;
    logic [15:0] qv;
    logic [2:0]  typ;
    int unsigned enCyc;
  } exp_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int unsigned nCmp = 0;
  int unsigned nErr = 0;
  int unsigned cyc = 0;
  int unsigned lastAcc = 0;
  exp_t sbq[$];
  exp_t monE;

  feedback_packet_rx_if #(.ERR_W(EW)) bus ();

  feedback_packet_rx #(
    .NODE_ID    (16'h0001),
    .TIMEOUT_CYC(64),
    .ERR_W      (EW)
  ) dut (
    .clock(clock),
    .rst  (rst),
    .rx   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by cycle %0d, required finish earlier", cyc);
    $fatal(1, "watchdog expired");
  end

  // Every en pulse must match the oldest queued packet, both in content and timing.
  always @(negedge clock) begin
    if (bus.en === 1'b1) begin
      nCmp++;
      if (sbq.size() == 0) begin
        nErr++;
        $display("FAIL unexpected_en: got en=1 at cycle %0d, required no pulse", cyc);
      end else begin
        monE = sbq.pop_front();
        if ({bus.fSourceID, bus.fClusterID, bus.fEnergyLeft, bus.fQValue, bus.packetType} !==
            {monE.src, monE.clu, monE.eng, monE.qv, monE.typ}) begin
          nErr++;
          $display("FAIL en_fields: got %h %h %h %h t%0d, required %h %h %h %h t%0d",
                   bus.fSourceID, bus.fClusterID, bus.fEnergyLeft, bus.fQValue, bus.packetType,
                   monE.src, monE.clu, monE.eng, monE.qv, monE.typ);
        end
        nCmp++;
        if (cyc !== monE.enCyc) begin
          nErr++;
          $display("FAIL en_latency: got cycle %0d, required cycle %0d", cyc, monE.enCyc);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned t = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) begin
      nCmp++;
      nErr++;
      $display("FAIL rx_ready_wait: got rx_ready=%b after %0d cycles, required 1", bus.rx_ready, t);
    end
    @(posedge clock);
    @(negedge clock);
    lastAcc = cyc;
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [15:0] s, input logic [15:0] c,
                            input logic [15:0] e, input logic [15:0] q,
                            input bit expectIssue, input bit corruptCsum);
    logic [7:0] b[9];
    exp_t ex;
    b[0] = hdr;
    b[1] = s[15:8]; b[2] = s[7:0];
    b[3] = c[15:8]; b[4] = c[7:0];
    b[5] = e[15:8]; b[6] = e[7:0];
    b[7] = q[15:8]; b[8] = q[7:0];
    for (int i = 0; i < 9; i++) send_byte(b[i]);
`ifdef FEEDBACK_CSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      for (int i = 0; i < 9; i++) x ^= b[i];
      send_byte(corruptCsum ? (x ^ 8'h01) : x);
    end
`endif
    bus.rx_valid = 1'b0;
    if (expectIssue && !corruptCsum) begin
      ex.src = s; ex.clu = c; ex.eng = e; ex.qv = q; ex.typ = hdr[2:0];
      ex.enCyc = lastAcc + 1;
      sbq.push_back(ex);
    end
  endtask

  task automatic pulse_done();
    bus.upd_done = 1'b1;
    @(negedge clock);
    bus.upd_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clock);
    nCmp++;
    if ({bus.en, bus.fSourceID, bus.fClusterID, bus.fEnergyLeft, bus.fQValue, bus.packetType,
         bus.busy, bus.err_count, bus.drop_count, bus.rx_ready} !== {{RZ{1'b0}}, 1'b1}) begin
      nErr++;
      $display("FAIL reset_outputs: got en=%b busy=%b err=%h drop=%h rdy=%b src=%h, required all 0 and rdy=1",
               bus.en, bus.busy, bus.err_count, bus.drop_count, bus.rx_ready, bus.fSourceID);
    end
    rst = 1'b0;
    @(negedge clock);
    nCmp++;
    if ({bus.rx_ready, bus.busy} !== 2'b10) begin
      nErr++;
      $display("FAIL reset_release: got rdy=%b busy=%b, required rdy=1 busy=0", bus.rx_ready, bus.busy);
    end
  endtask

  task automatic test_nominal();
    send_frame(8'h01, 16'h0005, 16'h0002, 16'h03E8, 16'h7F00, 1'b1, 1'b0);
    nCmp++;
    if ({bus.rx_ready, bus.en} !== 2'b00) begin
      nErr++;
      $display("FAIL nominal_chk: got rdy=%b en=%b, required 0 0", bus.rx_ready, bus.en);
    end
    @(negedge clock);
    nCmp++;
    if (bus.en !== 1'b1) begin
      nErr++;
      $display("FAIL nominal_en: got en=%b, required 1", bus.en);
    end
    @(negedge clock);
    nCmp++;
    if ({bus.en, bus.rx_ready, bus.busy} !== 3'b001) begin
      nErr++;
      $display("FAIL nominal_pulse_end: got en=%b rdy=%b busy=%b, required 0 0 1",
               bus.en, bus.rx_ready, bus.busy);
    end
    bus.upd_done = 1'b0;
    repeat (5) @(negedge clock);
    nCmp++;
    if ({bus.rx_ready, bus.fSourceID, bus.fQValue} !== {1'b0, 16'h0005, 16'h7F00}) begin
      nErr++;
      $display("FAIL nominal_hold: got rdy=%b src=%h q=%h, required 0 0005 7f00",
               bus.rx_ready, bus.fSourceID, bus.fQValue);
    end
    pulse_done();
    nCmp++;
    if ({bus.rx_ready, bus.busy} !== 2'b10) begin
      nErr++;
      $display("FAIL nominal_done: got rdy=%b busy=%b, required 1 0", bus.rx_ready, bus.busy);
    end
  endtask

  task automatic test_drop();
    send_frame(8'h01, 16'h0001, 16'h0002, 16'h03E8, 16'h7F00, 1'b0, 1'b0);
    nCmp++;
    if (bus.rx_ready !== 1'b0) begin
      nErr++;
      $display("FAIL drop_chk_ready: got %b, required 0", bus.rx_ready);
    end
    @(negedge clock);
    nCmp++;
    if ({bus.rx_ready, bus.drop_count, bus.fSourceID, bus.fEnergyLeft} !==
        {1'b1, 8'h01, 16'h0005, 16'h03E8}) begin
      nErr++;
      $display("FAIL drop_result: got rdy=%b drop=%h src=%h eng=%h, required 1 01 0005 03e8",
               bus.rx_ready, bus.drop_count, bus.fSourceID, bus.fEnergyLeft);
    end
  endtask

  task automatic test_bad_header();
    send_byte(8'h07);
    bus.rx_valid = 1'b0;
    nCmp++;
    if ({bus.busy, bus.rx_ready, bus.err_count} !== {1'b0, 1'b1, 8'h00}) begin
      nErr++;
      $display("FAIL badhdr_discard: got busy=%b rdy=%b err=%h, required 0 1 00",
               bus.busy, bus.rx_ready, bus.err_count);
    end
    pulse_done();
    send_frame(8'hF4, 16'h1234, 16'h00AB, 16'hFFFF, 16'h8001, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    pulse_done();
    nCmp++;
    if ({bus.err_count, bus.rx_ready, bus.packetType} !== {8'h00, 1'b1, 3'd4}) begin
      nErr++;
      $display("FAIL badhdr_follow: got err=%h rdy=%b type=%0d, required 00 1 4",
               bus.err_count, bus.rx_ready, bus.packetType);
    end
  endtask

  task automatic test_timeout();
    bit stayedBusy = 1'b1;
    send_byte(8'h02);
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i));
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 63; i++) begin
      @(negedge clock);
      if (bus.busy !== 1'b1) stayedBusy = 1'b0;
    end
    nCmp++;
    if (!stayedBusy) begin
      nErr++;
      $display("FAIL timeout_early: got abort before 64 idle cycles, required busy through 63");
    end
    @(negedge clock);
    nCmp++;
    if ({bus.busy, bus.err_count, bus.fSourceID, bus.rx_ready} !== {1'b0, 8'h01, 16'h1234, 1'b1}) begin
      nErr++;
      $display("FAIL timeout_abort: got busy=%b err=%h src=%h rdy=%b, required 0 01 1234 1",
               bus.busy, bus.err_count, bus.fSourceID, bus.rx_ready);
    end
    send_frame(8'h03, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    pulse_done();
  endtask

`ifdef FEEDBACK_CSUM_EN
  task automatic test_checksum();
    send_frame(8'h02, 16'h0005, 16'h0002, 16'h03E8, 16'h7F00, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    pulse_done();
    send_frame(8'h02, 16'h0005, 16'h0002, 16'h03E8, 16'h7F00, 1'b1, 1'b1);
    nCmp++;
    if ({bus.err_count, bus.busy, bus.rx_ready} !== {8'h02, 1'b0, 1'b1}) begin
      nErr++;
      $display("FAIL csum_bad: got err=%h busy=%b rdy=%b, required 02 0 1",
               bus.err_count, bus.busy, bus.rx_ready);
    end
    repeat (3) @(negedge clock);
  endtask
`endif

  task automatic test_reset_midframe();
    send_frame(8'h01, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    nCmp++;
    if ({bus.en, bus.fSourceID, bus.fClusterID, bus.fEnergyLeft, bus.fQValue, bus.packetType,
         bus.busy, bus.err_count, bus.drop_count, bus.rx_ready} !== {{RZ{1'b0}}, 1'b1}) begin
      nErr++;
      $display("FAIL rst_in_wait: got busy=%b rdy=%b src=%h err=%h drop=%h, required 0 1 0000 00 00",
               bus.busy, bus.rx_ready, bus.fSourceID, bus.err_count, bus.drop_count);
    end
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'h55);
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    nCmp++;
    if ({bus.busy, bus.rx_ready, bus.en} !== 3'b010) begin
      nErr++;
      $display("FAIL rst_in_body: got busy=%b rdy=%b en=%b, required 0 1 0", bus.busy, bus.rx_ready, bus.en);
    end
    send_frame(8'h04, 16'hBEEF, 16'h0007, 16'h0009, 16'h000B, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    pulse_done();
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    nCmp++;
    if (bus.err_count !== 8'h00) begin
      nErr++;
      $display("FAIL sat_start: got err=%h, required 00", bus.err_count);
    end
    for (int n = 0; n < 300; n++) begin
      send_byte(8'h01);
      bus.rx_valid = 1'b0;
      repeat (66) @(negedge clock);
    end
    nCmp++;
    if ({bus.err_count, bus.busy} !== {8'hFF, 1'b0}) begin
      nErr++;
      $display("FAIL sat_err: got err=%h busy=%b, required ff 0", bus.err_count, bus.busy);
    end
  endtask

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.upd_done = 1'b0;
    test_reset();
    test_nominal();
    test_drop();
    test_bad_header();
    test_timeout();
`ifdef FEEDBACK_CSUM_EN
    test_checksum();
`endif
    test_reset_midframe();
    test_saturation();
    nCmp++;
    if (sbq.size() != 0) begin
      nErr++;
      $display("FAIL missing_en: got %0d queued packets never issued, required 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
